// File: rtl/psum_normalizer_mc.sv
// Multi-channel L1 normaliser for systolic-array psum rows.
// Sums magnitudes over a row, then streams per-column ratios with backpressure.
`timescale 1ns/1ps
module psum_normalizer_mc #(
  parameter int BW_PSUM   = 16,
  parameter int COL       = 8,
  parameter int N_CH      = 2,
  parameter int FRAC_BITS = 8,
  parameter int W_OUT     = 16
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_mode,
  input  logic [N_CH*COL*BW_PSUM-1:0] s_psum,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [N_CH*W_OUT-1:0]       m_data,
  output logic                        m_last,
  output logic                        m_zero
);
  localparam int SW  = BW_PSUM + $clog2(N_CH*COL);
  localparam int CW  = $clog2(COL) + 1;
  localparam int NW  = BW_PSUM + FRAC_BITS;
  localparam int DW0 = (NW > SW) ? NW : SW;
  localparam int DW  = (DW0 > W_OUT) ? DW0 : W_OUT;

  typedef enum logic [1:0] {IDLE, SUM, DIV} state_t;

  state_t state_q, state_d;

  logic [COL-1:0][BW_PSUM-1:0] row_q [N_CH];
  logic                        mode_q;
  logic [SW-1:0]               sum_q;
  logic [CW-1:0]               cnt_q;
  logic                        ready_q;
  logic                        valid_q;
  logic                        last_q;
  logic                        zero_q;
  logic [N_CH*W_OUT-1:0]       data_q;

  logic                  accept;
  logic                  hs_last;
  logic                  load;
  logic [SW-1:0]         col_sum;
  logic [DW-1:0]         den;
  logic [DW-1:0]         num [N_CH];
  logic [DW-1:0]         quo [N_CH];
  logic [N_CH*W_OUT-1:0] quo_sat;

  // Magnitude is unsigned, so |-2^(BW-1)| still fits
  function automatic logic [BW_PSUM-1:0] mag(
    input logic [BW_PSUM-1:0] x,
    input logic               relu
  );
    if (!x[BW_PSUM-1]) return x;
    if (relu) return '0;
    return -x;
  endfunction

  assign accept  = (state_q == IDLE) && s_valid && ready_q;
  assign hs_last = valid_q && m_ready && last_q;
  assign load    = (state_q == DIV) && (!valid_q || m_ready)
                && (cnt_q != CW'(COL));

  always_comb begin
    col_sum = '0;
    for (int c = 0; c < N_CH; c++)
      col_sum = col_sum + SW'(mag(row_q[c][0], mode_q));
  end

  // Divisor is kept non-zero; zero-sum rows are forced to 0 anyway
  assign den = (sum_q == '0) ? DW'(1) : DW'(sum_q);

  always_comb begin
    quo_sat = '0;
    for (int c = 0; c < N_CH; c++) begin
      num[c] = DW'(mag(row_q[c][0], mode_q)) << FRAC_BITS;
      quo[c] = num[c] / den;
      if (sum_q == '0)
        quo_sat[c*W_OUT +: W_OUT] = '0;
      else if (|(quo[c] >> W_OUT))
        quo_sat[c*W_OUT +: W_OUT] = '1;
      else
        quo_sat[c*W_OUT +: W_OUT] = quo[c][W_OUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SUM;
      SUM:  if (cnt_q == CW'(COL-1)) state_d = DIV;
      DIV:  if (hs_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) row_q[c] <= '0;
      mode_q  <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            for (int c = 0; c < N_CH; c++)
              row_q[c] <= s_psum[c*COL*BW_PSUM +: COL*BW_PSUM];
            mode_q  <= s_mode;
            sum_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SUM: begin
          sum_q <= sum_q + col_sum;
          for (int c = 0; c < N_CH; c++)
            row_q[c] <= {row_q[c][0], row_q[c][COL-1:1]};
          if (cnt_q == CW'(COL-1)) cnt_q <= '0;
          else                     cnt_q <= cnt_q + 1'b1;
        end
        DIV: begin
          if (hs_last) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else if (load) begin
            data_q  <= quo_sat;
            valid_q <= 1'b1;
            last_q  <= (cnt_q == CW'(COL-1));
            zero_q  <= (sum_q == '0);
            for (int c = 0; c < N_CH; c++)
              row_q[c] <= {row_q[c][0], row_q[c][COL-1:1]};
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready = ready_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_zero  = zero_q;
  assign m_data  = data_q;

endmodule
